// File: rtl/vram_fill_seq.sv
// vram_fill_seq: walks NUM_CH programmed fill channels (base, length, pattern)
// and writes one word per accepted mem handshake. Optional per-frame scroll
// register write on vsync rising edge, enabled by macro VRAM_FILL_SCROLL_EN.
module vram_fill_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 8,
    parameter int LEN_W  = 20,
    parameter logic [ADDR_W-1:0] SCROLL_ADDR  = ADDR_W'(32'h0600_028F),
    parameter logic [DATA_W-1:0] SCROLL_FLAGS = DATA_W'(32'h8000_0000),
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_field,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              vsync,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic              mem_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_FILL   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
`ifdef VRAM_FILL_SCROLL_EN
    localparam logic [2:0] S_SCROLL = 3'd4;
`endif

    logic [2:0]             state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [LEN_W-1:0]       i_q, i_d;

    logic [NUM_CH-1:0][ADDR_W-1:0] base_q;
    logic [NUM_CH-1:0][LEN_W-1:0]  len_q;
    logic [NUM_CH-1:0][1:0]        mode_q;
    logic [NUM_CH-1:0][4:0]        shift_q;
    logic [NUM_CH-1:0][DATA_W-1:0] seed_q;

    logic                   last_ch;
    logic [DATA_W-1:0]      iw, mask, fill_data;

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign mem_we = mem_en;

`ifdef VRAM_FILL_SCROLL_EN
    logic       vsync_q, scroll_pend_q;
    logic [8:0] sx_q;
    logic [7:0] sy_q;
    logic       scroll_take, scroll_acc;

    // start has priority over a pending scroll in IDLE
    assign scroll_take = (state_q == S_IDLE) && !start && scroll_pend_q;
    assign scroll_acc  = (state_q == S_SCROLL) && mem_ready;

    // vsync edge detect, pending flag (edges collapse) and scroll counters
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q       <= 1'b0;
            scroll_pend_q <= 1'b0;
            sx_q          <= '0;
            sy_q          <= '0;
        end else begin
            vsync_q <= vsync;
            if (vsync && !vsync_q)
                scroll_pend_q <= 1'b1;
            else if (scroll_take)
                scroll_pend_q <= 1'b0;
            if (scroll_acc) begin
                sx_q <= sx_q + 9'd1;
                sy_q <= sy_q + 8'd1;
            end
        end
    end
`else
    wire unused_scroll = ^{SCROLL_ADDR, SCROLL_FLAGS, vsync};
`endif

    // channel register file; writes locked out while a sequence runs
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            shift_q <= '0;
            seed_q  <= '0;
        end else if (cfg_we && !busy && (int'(cfg_ch) < NUM_CH)) begin
            case (cfg_field)
                2'd0: base_q[cfg_ch] <= ADDR_W'(cfg_wdata);
                2'd1: len_q[cfg_ch]  <= LEN_W'(cfg_wdata);
                2'd2: begin
                    mode_q[cfg_ch]  <= cfg_wdata[1:0];
                    shift_q[cfg_ch] <= cfg_wdata[8:4];
                end
                default: seed_q[cfg_ch] <= cfg_wdata;
            endcase
        end
    end

    // pattern generator for the current element
    always_comb begin
        iw   = DATA_W'(i_q);
        mask = (DATA_W'(1) << shift_q[ch_q]) - DATA_W'(1);
        case (mode_q[ch_q])
            2'd0:    fill_data = seed_q[ch_q];
            2'd1:    fill_data = seed_q[ch_q] + iw;
            2'd2:    fill_data = seed_q[ch_q] + (iw >> shift_q[ch_q]);
            default: fill_data = seed_q[ch_q] + (iw & mask);
        endcase
    end

    // sequencer next state: one LOAD per channel, FILL advances on accept
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        i_d     = i_q;
        last_ch = (ch_q == CH_W'(NUM_CH - 1));
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ch_d    = '0;
                end
`ifdef VRAM_FILL_SCROLL_EN
                else if (scroll_pend_q) begin
                    state_d = S_SCROLL;
                end
`endif
            end
            S_LOAD: begin
                i_d = '0;
                if (len_q[ch_q] == '0) begin
                    if (last_ch) state_d = S_DONE;
                    else         ch_d    = ch_q + 1'b1;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ready) begin
                    if (i_q == len_q[ch_q] - LEN_W'(1)) begin
                        if (last_ch) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LOAD;
                            ch_d    = ch_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + LEN_W'(1);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
`ifdef VRAM_FILL_SCROLL_EN
            S_SCROLL: if (mem_ready) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            i_q     <= i_d;
        end
    end

    // memory request: purely a function of state, so it holds during stalls
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (state_q == S_FILL) begin
            mem_en   = 1'b1;
            mem_addr = base_q[ch_q] + ADDR_W'(i_q);
            mem_din  = fill_data;
        end
`ifdef VRAM_FILL_SCROLL_EN
        if (state_q == S_SCROLL) begin
            mem_en   = 1'b1;
            mem_addr = SCROLL_ADDR;
            mem_din  = SCROLL_FLAGS | DATA_W'({sx_q, 8'h00}) | DATA_W'(sy_q);
        end
`endif
    end

endmodule

// File: tb/tb_vram_fill_seq.sv
// Directed testbench for vram_fill_seq (default parameters, NUM_CH=8).
module tb_vram_fill_seq;

    localparam int CH_W = 3;
    localparam logic [31:0] SCR_A = 32'h0600_028F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [CH_W-1:0] cfg_ch = '0;
    logic [1:0]  cfg_field = '0;
    logic [31:0] cfg_wdata = '0;
    logic        start = 1'b0;
    logic        busy, done;
    logic        vsync = 1'b0;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_din;
    logic        mem_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vram_fill_seq dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .start(start),
        .busy(busy), .done(done), .vsync(vsync), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_ready(mem_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int field, input logic [31:0] d);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_field = 2'(field); cfg_wdata = d;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] base, input logic [31:0] len,
                          input logic [31:0] ms, input logic [31:0] seed);
        cfg(ch, 0, base); cfg(ch, 1, len); cfg(ch, 2, ms); cfg(ch, 3, seed);
    endtask

    task automatic test_reset;
        rst = 1'b1; tick; tick;
        n_cmp++;
        if ({busy, done, mem_en, mem_we} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, mem_en, mem_we});
        end
        n_cmp++;
        if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_cmp++;
        if (mem_din !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h want 0", mem_din); end
        rst = 1'b0; tick;
    endtask

    // ch0 MOD shift 8: data = i % 256
    task automatic test_mod_fill;
        int cyc, nw, bad, first_en, ndone;
        logic [31:0] last_a, bad_a, bad_d;
        bit busy1;
        set_ch(0, 32'h0610_0000, 2048, 32'h83, 32'h0);
        mem_ready = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        busy1 = busy;
        cyc = 0; nw = 0; bad = 0; first_en = -1; last_a = '0; bad_a = '0; bad_d = '0;
        for (int c = 0; c < 2200; c++) begin
            cyc++;
            if (mem_en) begin
                if (first_en < 0) first_en = cyc;
                if (mem_addr !== 32'h0610_0000 + 32'(nw) || mem_din !== 32'(nw % 256) || mem_we !== 1'b1) begin
                    if (bad == 0) begin bad_a = mem_addr; bad_d = mem_din; end
                    bad++;
                end
                last_a = mem_addr; nw++;
            end
            if (done) break;
            tick;
        end
        n_cmp++;
        if (busy1 !== 1'b1) begin n_bad++; $display("FAIL mod_busy_k1: got %b want 1", busy1); end
        n_cmp++;
        if (first_en != 2) begin n_bad++; $display("FAIL mod_first_en: got cycle %0d want 2", first_en); end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL mod_data: %0d bad writes, first addr %h data %h", bad, bad_a, bad_d); end
        n_cmp++;
        if (nw != 2048) begin n_bad++; $display("FAIL mod_count: got %0d want 2048", nw); end
        n_cmp++;
        if (last_a !== 32'h0610_07FF) begin n_bad++; $display("FAIL mod_last_addr: got %h want 061007ff", last_a); end
        n_cmp++;
        if (cyc != 2057) begin n_bad++; $display("FAIL mod_cycles: got %0d want 2057", cyc); end
        ndone = 0;
        for (int c = 0; c < 4; c++) begin tick; if (done) ndone++; end
        n_cmp++;
        if (ndone != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mod_done_once: extra dones %0d busy %b want 0/0", ndone, busy);
        end
    endtask

    // ch0 DIV shift 6: data = i >> 6
    task automatic test_div_fill;
        int cyc, nw, bad;
        logic [31:0] d63, d64, dlast;
        set_ch(0, 32'h0620_0000, 16384, 32'h62, 32'h0);
        start = 1'b1; tick; start = 1'b0;
        cyc = 0; nw = 0; bad = 0; d63 = 'x; d64 = 'x; dlast = 'x;
        for (int c = 0; c < 16500; c++) begin
            cyc++;
            if (mem_en) begin
                if (mem_addr !== 32'h0620_0000 + 32'(nw) || mem_din !== 32'(nw >> 6)) bad++;
                if (nw == 63) d63 = mem_din;
                if (nw == 64) d64 = mem_din;
                if (nw == 16383) dlast = mem_din;
                nw++;
            end
            if (done) break;
            tick;
        end
        n_cmp++;
        if (bad != 0 || nw != 16384) begin n_bad++; $display("FAIL div_stream: bad %0d count %0d want 0/16384", bad, nw); end
        n_cmp++;
        if (d63 !== 32'd0 || d64 !== 32'd1) begin n_bad++; $display("FAIL div_step: i63 %h i64 %h want 0/1", d63, d64); end
        n_cmp++;
        if (dlast !== 32'd255) begin n_bad++; $display("FAIL div_last: got %h want ff", dlast); end
        n_cmp++;
        if (cyc != 16393) begin n_bad++; $display("FAIL div_cycles: got %0d want 16393", cyc); end
        tick;
    endtask

    // three CONST channels (last one wraps the address space) under random stalls
    task automatic test_stall;
        logic [31:0] ea [12];
        logic [31:0] ed [12];
        logic [31:0] pa, pd;
        int nw, bad, hold_bad, k;
        bit pstall, seen_done;
        set_ch(0, 32'h0000_0100, 5, 32'h0, 32'hA5A5_0000);
        set_ch(1, 32'h0000_0200, 3, 32'h0, 32'h1111_1111);
        set_ch(2, 32'hFFFF_FFFE, 4, 32'h0, 32'h0000_C0DE);
        k = 0;
        for (int i = 0; i < 5; i++) begin ea[k] = 32'h100 + 32'(i); ed[k] = 32'hA5A5_0000; k++; end
        for (int i = 0; i < 3; i++) begin ea[k] = 32'h200 + 32'(i); ed[k] = 32'h1111_1111; k++; end
        for (int i = 0; i < 4; i++) begin ea[k] = 32'hFFFF_FFFE + 32'(i); ed[k] = 32'h0000_C0DE; k++; end
        start = 1'b1; tick; start = 1'b0;
        nw = 0; bad = 0; hold_bad = 0; pstall = 0; seen_done = 0; pa = '0; pd = '0;
        for (int c = 0; c < 500; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            if (pstall && (mem_en !== 1'b1 || mem_addr !== pa || mem_din !== pd)) hold_bad++;
            if (mem_en && mem_ready) begin
                if (nw >= 12 || mem_addr !== ea[nw] || mem_din !== ed[nw]) bad++;
                nw++;
            end
            pstall = mem_en && !mem_ready; pa = mem_addr; pd = mem_din;
            if (done) begin seen_done = 1; break; end
            tick;
        end
        mem_ready = 1'b1;
        n_cmp++;
        if (bad != 0 || nw != 12) begin n_bad++; $display("FAIL stall_seq: bad %0d count %0d want 0/12", bad, nw); end
        n_cmp++;
        if (hold_bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_bad); end
        n_cmp++;
        if (!seen_done) begin n_bad++; $display("FAIL stall_done: got no done want done"); end
        tick;
    endtask

    // every channel empty: done at k+9, no writes
    task automatic test_all_zero;
        int cyc, nen;
        for (int ch = 0; ch < 3; ch++) cfg(ch, 1, 32'h0);
        start = 1'b1; tick; start = 1'b0;
        cyc = 0; nen = 0;
        for (int c = 0; c < 40; c++) begin
            cyc++;
            if (mem_en) nen++;
            if (done) break;
            tick;
        end
        n_cmp++;
        if (cyc != 9) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 9", cyc); end
        n_cmp++;
        if (nen != 0) begin n_bad++; $display("FAIL zero_no_write: got %0d want 0", nen); end
        tick;
    endtask

    // reset in the middle of a fill, then a start with cleared config
    task automatic test_rst_mid;
        int cyc, nen;
        bit found;
        set_ch(0, 32'h0700_0000, 200, 32'h1, 32'h10);
        start = 1'b1; tick; start = 1'b0;
        found = 0;
        for (int c = 0; c < 300; c++) begin
            if (mem_en && mem_addr === 32'h0700_0064) begin found = 1; break; end
            tick;
        end
        n_cmp++;
        if (!found || mem_din !== 32'h74) begin n_bad++; $display("FAIL rst_reach_i100: found %0b data %h want 1/74", found, mem_din); end
        rst = 1'b1; tick;
        n_cmp++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0) begin
            n_bad++; $display("FAIL rst_mid: en %b busy %b addr %h want 0/0/0", mem_en, busy, mem_addr);
        end
        rst = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        cyc = 0; nen = 0;
        for (int c = 0; c < 40; c++) begin
            cyc++;
            if (mem_en) nen++;
            if (done) break;
            tick;
        end
        n_cmp++;
        if (nen != 0 || cyc != 9) begin n_bad++; $display("FAIL rst_after_start: writes %0d done cycle %0d want 0/9", nen, cyc); end
        tick;
    endtask

`ifdef VRAM_FILL_SCROLL_EN
    // one vsync pulse in IDLE; returns the observed scroll request
    task automatic scroll_once(output bit got, output logic [31:0] a, output logic [31:0] d);
        got = 0; a = '0; d = '0;
        vsync = 1'b1; tick; vsync = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (mem_en) begin got = 1; a = mem_addr; d = mem_din; break; end
            tick;
        end
        tick;
    endtask

    task automatic test_scroll;
        bit got, dseen, after_done;
        logic [31:0] a, d, e, sd;
        int nfill, nscr, bad;
        for (int k = 0; k < 3; k++) begin
            scroll_once(got, a, d);
            e = 32'h8000_0000 + 32'(k) * 32'h101;
            n_cmp++;
            if (!got || a !== SCR_A || d !== e) begin
                n_bad++; $display("FAIL scroll_idle%0d: got %0b addr %h data %h want %h/%h", k, got, a, d, SCR_A, e);
            end
        end
        // edge during a fill: serviced once after done
        set_ch(0, 32'h0000_0500, 20, 32'h0, 32'h7);
        start = 1'b1; tick; start = 1'b0;
        nfill = 0; nscr = 0; dseen = 0; after_done = 0; sd = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) vsync = 1'b1;
            if (c == 6) vsync = 1'b0;
            if (done) dseen = 1;
            if (mem_en) begin
                if (mem_addr === SCR_A) begin nscr++; sd = mem_din; after_done = dseen; end
                else nfill++;
            end
            tick;
        end
        n_cmp++;
        if (nfill != 20 || nscr != 1) begin n_bad++; $display("FAIL scroll_fill_counts: fill %0d scroll %0d want 20/1", nfill, nscr); end
        n_cmp++;
        if (sd !== 32'h8000_0303 || !after_done) begin
            n_bad++; $display("FAIL scroll_after_done: data %h after_done %0b want 80000303/1", sd, after_done);
        end
        // run the counters to 512 writes, then check the wrap
        bad = 0;
        for (int n = 4; n < 512; n++) begin
            scroll_once(got, a, d);
            e = 32'h8000_0000 | (32'(n % 512) << 8) | 32'(n % 256);
            if (!got || d !== e) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL scroll_bulk: got %0d bad writes want 0", bad); end
        scroll_once(got, a, d);
        n_cmp++;
        if (!got || d !== 32'h8000_0000) begin n_bad++; $display("FAIL scroll_wrap: got %h want 80000000", d); end
    endtask
`endif

    initial begin
        test_reset;
        test_mod_fill;
        test_div_fill;
        test_stall;
        test_all_zero;
        test_rst_mid;
`ifdef VRAM_FILL_SCROLL_EN
        test_scroll;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
